// File: rtl/cpc_pal_sync_gen.sv
// cpc_pal_sync_gen
//   15 kHz PAL-style raster timing generator for the clkvideo domain.
//   Produces hsync_n, vsync_n and a composite csync_n that carries
//   equalising and broad (serrated) pulses around vertical sync. It also
//   exports the raster counters for the pixel fetch logic and blanks the
//   incoming 3:3:3 RGB outside the active window.
//
// Ports
//   clkvideo    : pixel-domain clock
//   rst         : synchronous active-high reset (priority over ce)
//   ce          : pixel enable; all registers advance only when high
//   ri/gi/bi    : 3-bit RGB from the fetch logic
//   hcount      : current column, 0..H_TOTAL-1
//   vcount      : current line, 0..V_TOTAL-1
//   display_en  : high inside the active window
//   hsync_n     : horizontal sync, active low
//   vsync_n     : vertical sync, active low
//   csync_n     : composite sync, active low
//   ro/go/bo    : RGB forced to black outside the active window
//   frame_start : high while hcount=0 and vcount=0
module cpc_pal_sync_gen #(
    parameter int H_TOTAL     = 768,
    parameter int HSYNC_W     = 56,
    parameter int EQ_W        = 28,
    parameter int H_ACT_START = 128,
    parameter int H_ACTIVE    = 576,
    parameter int V_TOTAL     = 312,
    parameter int VSYNC_LINES = 3,
    parameter int EQ_LINES    = 3,
    parameter int V_ACT_START = 32,
    parameter int V_ACTIVE    = 272
) (
    input  logic       clkvideo,
    input  logic       rst,
    input  logic       ce,
    input  logic [2:0] ri,
    input  logic [2:0] gi,
    input  logic [2:0] bi,
    output logic [9:0] hcount,
    output logic [8:0] vcount,
    output logic       display_en,
    output logic       hsync_n,
    output logic       vsync_n,
    output logic       csync_n,
    output logic [2:0] ro,
    output logic [2:0] go,
    output logic [2:0] bo,
    output logic       frame_start
);

    localparam logic [9:0] HT_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] HALF_LINE    = 10'(H_TOTAL / 2);
    localparam logic [9:0] HS_WIDTH     = 10'(HSYNC_W);
    localparam logic [9:0] EQ_WIDTH     = 10'(EQ_W);
    localparam logic [9:0] BROAD_WIDTH  = 10'(H_TOTAL / 2 - HSYNC_W);
    localparam logic [9:0] HA_START     = 10'(H_ACT_START);
    localparam logic [9:0] HA_END       = 10'(H_ACT_START + H_ACTIVE);
    localparam logic [8:0] VT_LAST      = 9'(V_TOTAL - 1);
    localparam logic [8:0] VS_END       = 9'(VSYNC_LINES);
    localparam logic [8:0] POST_EQ_END  = 9'(VSYNC_LINES + EQ_LINES);
    localparam logic [8:0] PRE_EQ_START = 9'(V_TOTAL - EQ_LINES);
    localparam logic [8:0] VA_START     = 9'(V_ACT_START);
    localparam logic [8:0] VA_END       = 9'(V_ACT_START + V_ACTIVE);

    typedef enum logic [1:0] {
        LINE_NORMAL,
        LINE_VSYNC,
        LINE_POST_EQ,
        LINE_PRE_EQ
    } line_region_t;

    logic [9:0]   h_next;
    logic [8:0]   v_next;
    logic [9:0]   hpos;
    line_region_t region;
    logic         hsync_next;
    logic         vsync_next;
    logic         csync_next;
    logic         de_next;
    logic         fs_next;
    logic [8:0]   rgb_next;

    // Everything is decoded from the position being entered, so the
    // registered outputs line up with the counters presented alongside them.
    always_comb begin
        h_next = hcount;
        v_next = vcount;
        if (hcount == HT_LAST) begin
            h_next = '0;
            if (vcount == VT_LAST) begin
                v_next = '0;
            end else begin
                v_next = vcount + 9'd1;
            end
        end else begin
            h_next = hcount + 10'd1;
        end

        // Position within the current half line; serration and equalising
        // pulses repeat every half line.
        if (h_next >= HALF_LINE) begin
            hpos = h_next - HALF_LINE;
        end else begin
            hpos = h_next;
        end

        if (v_next < VS_END) begin
            region = LINE_VSYNC;
        end else if (v_next < POST_EQ_END) begin
            region = LINE_POST_EQ;
        end else if (v_next >= PRE_EQ_START) begin
            region = LINE_PRE_EQ;
        end else begin
            region = LINE_NORMAL;
        end

        hsync_next = !(h_next < HS_WIDTH);
        vsync_next = !(v_next < VS_END);

        case (region)
            LINE_VSYNC:   csync_next = !(hpos < BROAD_WIDTH);
            LINE_POST_EQ: csync_next = !(hpos < EQ_WIDTH);
            LINE_PRE_EQ:  csync_next = !(hpos < EQ_WIDTH);
            default:      csync_next = hsync_next;
        endcase

        de_next  = (h_next >= HA_START) && (h_next < HA_END) &&
                   (v_next >= VA_START) && (v_next < VA_END);
        fs_next  = (h_next == '0) && (v_next == '0);
        rgb_next = de_next ? {ri, gi, bi} : '0;
    end

    // Reset parks the raster on its last position; the outputs below are
    // exactly the decode of that position, so the first ce enters (0,0)
    // without a glitch.
    always_ff @(posedge clkvideo) begin
        if (rst) begin
            hcount      <= HT_LAST;
            vcount      <= VT_LAST;
            hsync_n     <= 1'b1;
            vsync_n     <= 1'b1;
            csync_n     <= 1'b1;
            display_en  <= 1'b0;
            frame_start <= 1'b0;
            ro          <= '0;
            go          <= '0;
            bo          <= '0;
        end else if (ce) begin
            hcount       <= h_next;
            vcount       <= v_next;
            hsync_n      <= hsync_next;
            vsync_n      <= vsync_next;
            csync_n      <= csync_next;
            display_en   <= de_next;
            frame_start  <= fs_next;
            {ro, go, bo} <= rgb_next;
        end
    end

endmodule

// File: tb/tb_cpc_pal_sync_gen.sv
// tb_cpc_pal_sync_gen
//   Bench for cpc_pal_sync_gen. Two instances share clock and stimulus:
//   dut_a uses the default PAL timing, dut_b a small raster so that full
//   frames, the pre-equalising lines and frame wrap are reached quickly.
//   A raster model computes expected outputs from a linear pixel index.
module tb_cpc_pal_sync_gen;

    typedef struct {
        int ht; int hs; int eqw; int has; int ha;
        int vt; int vs; int eql; int vas; int va;
    } cfg_t;

    typedef struct {
        int   h;
        int   v;
        logic de;
        logic hs;
        logic vs;
        logic cs;
        logic fs;
    } vec_t;

    cfg_t cfg_a = '{768, 56, 28, 128, 576, 312, 3, 3, 32, 272};
    cfg_t cfg_b = '{96, 8, 4, 16, 64, 24, 2, 2, 5, 16};

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [2:0] ri, gi, bi;

    logic [9:0] hc_a, hc_b;
    logic [8:0] vc_a, vc_b;
    logic       de_a, de_b, hs_a, hs_b, vs_a, vs_b, cs_a, cs_b, fs_a, fs_b;
    logic [2:0] ro_a, go_a, bo_a, ro_b, go_b, bo_b;

    int checks = 0;
    int errors = 0;
    logic model_on = 1'b0;

    always #5 clk = ~clk;

    cpc_pal_sync_gen dut_a (
        .clkvideo(clk), .rst(rst), .ce(ce), .ri(ri), .gi(gi), .bi(bi),
        .hcount(hc_a), .vcount(vc_a), .display_en(de_a),
        .hsync_n(hs_a), .vsync_n(vs_a), .csync_n(cs_a),
        .ro(ro_a), .go(go_a), .bo(bo_a), .frame_start(fs_a)
    );

    cpc_pal_sync_gen #(
        .H_TOTAL(96), .HSYNC_W(8), .EQ_W(4), .H_ACT_START(16), .H_ACTIVE(64),
        .V_TOTAL(24), .VSYNC_LINES(2), .EQ_LINES(2), .V_ACT_START(5), .V_ACTIVE(16)
    ) dut_b (
        .clkvideo(clk), .rst(rst), .ce(ce), .ri(ri), .gi(gi), .bi(bi),
        .hcount(hc_b), .vcount(vc_b), .display_en(de_b),
        .hsync_n(hs_b), .vsync_n(vs_b), .csync_n(cs_b),
        .ro(ro_b), .go(go_b), .bo(bo_b), .frame_start(fs_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic in_window(cfg_t c, int pos);
        int h = pos % c.ht;
        int v = pos / c.ht;
        return (h >= c.has) && (h < c.has + c.ha) && (v >= c.vas) && (v < c.vas + c.va);
    endfunction

    // Expected {hcount, vcount, de, hs_n, vs_n, cs_n, fs, rgb} at a pixel index.
    function automatic logic [32:0] expect_vec(cfg_t c, int pos, logic [8:0] rgb);
        int   h  = pos % c.ht;
        int   v  = pos / c.ht;
        int   hl = c.ht / 2;
        int   hp = h % hl;
        logic hs = !(h < c.hs);
        logic vs = !(v < c.vs);
        logic cs;
        logic de = in_window(c, pos);
        logic fs = (pos == 0);
        if (v < c.vs)
            cs = !(hp < hl - c.hs);
        else if (v < c.vs + c.eql || v >= c.vt - c.eql)
            cs = !(hp < c.eqw);
        else
            cs = hs;
        return {10'(h), 9'(v), de, hs, vs, cs, fs, rgb};
    endfunction

    int         pos_a, pos_b;
    logic [8:0] rgb_a, rgb_b;

    always @(posedge clk) begin
        if (rst) begin
            pos_a <= cfg_a.ht * cfg_a.vt - 1;
            pos_b <= cfg_b.ht * cfg_b.vt - 1;
            rgb_a <= '0;
            rgb_b <= '0;
        end else if (ce) begin
            pos_a <= (pos_a + 1) % (cfg_a.ht * cfg_a.vt);
            pos_b <= (pos_b + 1) % (cfg_b.ht * cfg_b.vt);
            rgb_a <= in_window(cfg_a, (pos_a + 1) % (cfg_a.ht * cfg_a.vt)) ? {ri, gi, bi} : 9'd0;
            rgb_b <= in_window(cfg_b, (pos_b + 1) % (cfg_b.ht * cfg_b.vt)) ? {ri, gi, bi} : 9'd0;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            check($sformatf("model_a@%0d,%0d", pos_a % cfg_a.ht, pos_a / cfg_a.ht),
                  {hc_a, vc_a, de_a, hs_a, vs_a, cs_a, fs_a, ro_a, go_a, bo_a},
                  expect_vec(cfg_a, pos_a, rgb_a));
            check($sformatf("model_b@%0d,%0d", pos_b % cfg_b.ht, pos_b / cfg_b.ht),
                  {hc_b, vc_b, de_b, hs_b, vs_b, cs_b, fs_b, ro_b, go_b, bo_b},
                  expect_vec(cfg_b, pos_b, rgb_b));
        end
    end

    function automatic vec_t mk(int h, int v, logic [4:0] f);
        return '{h, v, f[4], f[3], f[2], f[1], f[0]};
    endfunction

    vec_t tbl[26];

    initial begin
        int guard;
        int n;

        // flags: {display_en, hsync_n, vsync_n, csync_n, frame_start}
        tbl[0]  = mk(0,   0,  5'b00001);
        tbl[1]  = mk(55,  0,  5'b00000);
        tbl[2]  = mk(56,  0,  5'b01000);
        tbl[3]  = mk(327, 0,  5'b01000);
        tbl[4]  = mk(328, 0,  5'b01010);
        tbl[5]  = mk(383, 0,  5'b01010);
        tbl[6]  = mk(384, 0,  5'b01000);
        tbl[7]  = mk(711, 2,  5'b01000);
        tbl[8]  = mk(712, 2,  5'b01010);
        tbl[9]  = mk(767, 2,  5'b01010);
        tbl[10] = mk(0,   3,  5'b00100);
        tbl[11] = mk(27,  3,  5'b00100);
        tbl[12] = mk(28,  3,  5'b00110);
        tbl[13] = mk(56,  3,  5'b01110);
        tbl[14] = mk(383, 4,  5'b01110);
        tbl[15] = mk(384, 4,  5'b01100);
        tbl[16] = mk(411, 5,  5'b01100);
        tbl[17] = mk(412, 5,  5'b01110);
        tbl[18] = mk(0,   6,  5'b00100);
        tbl[19] = mk(55,  6,  5'b00100);
        tbl[20] = mk(56,  6,  5'b01110);
        tbl[21] = mk(128, 31, 5'b01110);
        tbl[22] = mk(127, 32, 5'b01110);
        tbl[23] = mk(128, 32, 5'b11110);
        tbl[24] = mk(703, 32, 5'b11110);
        tbl[25] = mk(704, 32, 5'b01110);

        rst = 1'b1; ce = 1'b0; ri = '0; gi = '0; bi = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset_a", {hc_a, vc_a, de_a, hs_a, vs_a, cs_a, fs_a, ro_a, go_a, bo_a},
              {10'd767, 9'd311, 5'b01110, 9'd0});
        check("reset_b", {hc_b, vc_b, de_b, hs_b, vs_b, cs_b, fs_b, ro_b, go_b, bo_b},
              {10'd95, 9'd23, 5'b01110, 9'd0});
        model_on = 1'b1;

        // Full-rate run through the top of the default frame.
        rst = 1'b0; ce = 1'b1; ri = 3'd7; gi = 3'd5; bi = 3'd3;
        for (int i = 0; i < 26; i++) begin
            guard = 0;
            while (!(hc_a == 10'(tbl[i].h) && vc_a == 9'(tbl[i].v)) && guard < 30000) begin
                @(negedge clk);
                guard++;
            end
            check($sformatf("reach_%0d,%0d", tbl[i].h, tbl[i].v), {63'd0, guard < 30000}, 64'd1);
            check($sformatf("vec_%0d,%0d", tbl[i].h, tbl[i].v),
                  {de_a, hs_a, vs_a, cs_a, fs_a, ro_a, go_a, bo_a},
                  {tbl[i].de, tbl[i].hs, tbl[i].vs, tbl[i].cs, tbl[i].fs,
                   tbl[i].de ? 9'o753 : 9'o000});
        end

        // frame_start period on the small raster.
        guard = 0;
        while (!fs_b && guard < 3000) begin
            @(negedge clk);
            guard++;
        end
        check("fs_b_first", {63'd0, fs_b}, 64'd1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!fs_b && n < 5000);
        check("fs_b_period", 64'(n), 64'd2304);

        // Half-rate ce, then reset while ce is low.
        for (int i = 0; i < 21; i++) begin
            ce = (i % 2 == 0);
            @(negedge clk);
        end
        ce = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("midrst_a", {hc_a, vc_a, de_a, hs_a, vs_a, cs_a, fs_a}, {10'd767, 9'd311, 5'b01110});
        check("midrst_b", {hc_b, vc_b}, {10'd95, 9'd23});
        rst = 1'b0;
        @(negedge clk);
        check("hold_after_rst", {hc_a, vc_a}, {10'd767, 9'd311});
        ce = 1'b1;
        @(negedge clk);
        check("restart_a", {hc_a, vc_a, de_a, hs_a, vs_a, cs_a, fs_a}, {10'd0, 9'd0, 5'b00001});
        check("restart_b", {hc_b, vc_b, fs_b}, {10'd0, 9'd0, 1'b1});

        // Random enables, colours and occasional resets against the model.
        for (int i = 0; i < 20000; i++) begin
            ce  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 4999) == 0);
            ri  = 3'($urandom);
            gi  = 3'($urandom);
            bi  = 3'($urandom);
            @(negedge clk);
        end
        model_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
